cc_outcome_sequencer: RTL and testbench

Game-flow sequencer for the Frogger datapath. It consumes the 2-bit outcome code from the last-row comparator: 11 = frog reached the top row (win), 01 = collision, 00 = nothing. It then runs the resulting game sequence: flash the matrix, update lives and level, pulse a respawn to the frog register, and hold the game in GAME_OVER when lives run out. It sits between the comparator and the frog/lane shift registers and the matrix display mux.

---
 rtl/cc_outcome_sequencer.sv | 111 +++++++++++
 tb/tb_cc_outcome_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cc_outcome_sequencer.sv
// Frogger game-flow sequencer: turns comparator outcomes into flash,
// lives/level bookkeeping, respawn pulses and game-over hold.
module cc_outcome_sequencer #(
  parameter int LIVES_INIT  = 3,
  parameter int FLASH_TICKS = 4,
  parameter int LEVEL_WIDTH = 4
) (
  input  logic                   CC_OUTCOMESEQ_CLOCK_50,
  input  logic                   CC_OUTCOMESEQ_RESET_InLow,
  input  logic                   CC_OUTCOMESEQ_start_InLow,
  input  logic                   CC_OUTCOMESEQ_tick_InHigh,
  input  logic [1:0]             CC_OUTCOMESEQ_outcome_InBUS,
  output logic [2:0]             CC_OUTCOMESEQ_state_OutBUS,
  output logic [2:0]             CC_OUTCOMESEQ_lives_OutBUS,
  output logic [LEVEL_WIDTH-1:0] CC_OUTCOMESEQ_level_OutBUS,
  output logic                   CC_OUTCOMESEQ_respawn_OutHigh,
  output logic                   CC_OUTCOMESEQ_pause_OutHigh,
  output logic [7:0]             CC_OUTCOMESEQ_flash_OutBUS,
  output logic                   CC_OUTCOMESEQ_gameover_OutHigh
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_WIN     = 3'd2,
    S_HIT     = 3'd3,
    S_RESPAWN = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [3:0] LAST   = 4'(FLASH_TICKS - 1);
  localparam logic [2:0] LIVES0 = 3'(LIVES_INIT);

  state_t                 state;
  logic [2:0]             lives;
  logic [LEVEL_WIDTH-1:0] level;
  logic [3:0]             cnt;
  logic                   start;
  logic                   tick;
  logic [1:0]             outcome;

  assign start   = ~CC_OUTCOMESEQ_start_InLow;
  assign tick    = CC_OUTCOMESEQ_tick_InHigh;
  assign outcome = CC_OUTCOMESEQ_outcome_InBUS;

  always_ff @(posedge CC_OUTCOMESEQ_CLOCK_50 or negedge CC_OUTCOMESEQ_RESET_InLow) begin
    if (!CC_OUTCOMESEQ_RESET_InLow) begin
      state <= S_IDLE;
      lives <= LIVES0;
      level <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            lives <= LIVES0;
            level <= '0;
            state <= S_RESPAWN;
          end
        end
        S_PLAY: begin
          if (outcome == 2'b11) begin
            cnt   <= '0;
            state <= S_WIN;
          end else if (outcome == 2'b01) begin
            // lives is never below 1 here, but never let it wrap
            if (lives != 3'd0) lives <= lives - 3'd1;
            cnt   <= '0;
            state <= S_HIT;
          end
        end
        S_WIN: begin
          if (tick) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST) begin
              if (level != '1) level <= level + LEVEL_WIDTH'(1);
              state <= S_RESPAWN;
            end
          end
        end
        S_HIT: begin
          if (tick) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST) state <= (lives == 3'd0) ? S_OVER : S_RESPAWN;
          end
        end
        S_RESPAWN: state <= S_PLAY;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // outputs decode registered state only
  always_comb begin
    CC_OUTCOMESEQ_flash_OutBUS = 8'h00;
    case (state)
      S_WIN:   CC_OUTCOMESEQ_flash_OutBUS = cnt[0] ? 8'h00 : 8'hFF;
      S_HIT:   CC_OUTCOMESEQ_flash_OutBUS = cnt[0] ? 8'h55 : 8'hAA;
      S_OVER:  CC_OUTCOMESEQ_flash_OutBUS = 8'h81;
      default: CC_OUTCOMESEQ_flash_OutBUS = 8'h00;
    endcase
  end

  assign CC_OUTCOMESEQ_state_OutBUS     = state;
  assign CC_OUTCOMESEQ_lives_OutBUS     = lives;
  assign CC_OUTCOMESEQ_level_OutBUS     = level;
  assign CC_OUTCOMESEQ_respawn_OutHigh  = (state == S_RESPAWN);
  assign CC_OUTCOMESEQ_pause_OutHigh    = (state != S_PLAY);
  assign CC_OUTCOMESEQ_gameover_OutHigh = (state == S_OVER);

endmodule

// File: tb/tb_cc_outcome_sequencer.sv
// Directed bench for cc_outcome_sequencer: win, hit, game over,
// tick alignment, async reset abort and level saturation.
module tb_cc_outcome_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_n;
  logic       tick;
  logic [1:0] outcome;
  logic [2:0] state;
  logic [2:0] lives;
  logic [3:0] level;
  logic       respawn;
  logic       pause;
  logic [7:0] flash;
  logic       gameover;

  int checks   = 0;
  int failures = 0;

  cc_outcome_sequencer #(
    .LIVES_INIT (3),
    .FLASH_TICKS(4),
    .LEVEL_WIDTH(4)
  ) dut (
    .CC_OUTCOMESEQ_CLOCK_50        (clk),
    .CC_OUTCOMESEQ_RESET_InLow     (rst_n),
    .CC_OUTCOMESEQ_start_InLow     (start_n),
    .CC_OUTCOMESEQ_tick_InHigh     (tick),
    .CC_OUTCOMESEQ_outcome_InBUS   (outcome),
    .CC_OUTCOMESEQ_state_OutBUS    (state),
    .CC_OUTCOMESEQ_lives_OutBUS    (lives),
    .CC_OUTCOMESEQ_level_OutBUS    (level),
    .CC_OUTCOMESEQ_respawn_OutHigh (respawn),
    .CC_OUTCOMESEQ_pause_OutHigh   (pause),
    .CC_OUTCOMESEQ_flash_OutBUS    (flash),
    .CC_OUTCOMESEQ_gameover_OutHigh(gameover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_n = 1'b0;
    cyc();
    start_n = 1'b1;
    chk("start_state", 32'(state), 32'd4);
    chk("start_respawn", 32'(respawn), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_level", 32'(level), 32'd0);
    cyc();
    chk("start_play", 32'(state), 32'd1);
    chk("start_resp_off", 32'(respawn), 32'd0);
    chk("start_pause", 32'(pause), 32'd0);
  endtask

  task automatic do_hit(input logic [2:0] exp_lives, input bit last);
    outcome = 2'b01;
    cyc();
    outcome = 2'b00;
    chk("hit_state", 32'(state), 32'd3);
    chk("hit_lives", 32'(lives), 32'(exp_lives));
    for (int i = 0; i < 4; i++) begin
      chk("hit_flash", 32'(flash), (i % 2 == 0) ? 32'hAA : 32'h55);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (i < 3) begin
        chk("hit_hold", 32'(state), 32'd3);
        repeat (3) cyc();
      end
    end
    if (last) begin
      chk("over_state", 32'(state), 32'd5);
      chk("over_gameover", 32'(gameover), 32'd1);
      chk("over_flash", 32'(flash), 32'h81);
      chk("over_no_resp", 32'(respawn), 32'd0);
      cyc();
      chk("over_no_resp2", 32'(respawn), 32'd0);
    end else begin
      chk("hit_resp_state", 32'(state), 32'd4);
      chk("hit_respawn", 32'(respawn), 32'd1);
      cyc();
      chk("hit_back_play", 32'(state), 32'd1);
    end
  endtask

  task automatic fast_win();
    outcome = 2'b11;
    cyc();
    outcome = 2'b00;
    tick = 1'b1;
    repeat (4) cyc();
    tick = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n   = 1'b0;
    start_n = 1'b1;
    tick    = 1'b0;
    outcome = 2'b00;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pause", 32'(pause), 32'd1);
    chk("rst_flash", 32'(flash), 32'h00);
    chk("rst_respawn", 32'(respawn), 32'd0);

    do_start();

    // win with ticks spaced 10 clocks apart
    outcome = 2'b11;
    cyc();
    outcome = 2'b00;
    chk("win_state", 32'(state), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("win_flash", 32'(flash), (i % 2 == 0) ? 32'hFF : 32'h00);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (i < 3) begin
        chk("win_hold", 32'(state), 32'd2);
        chk("win_level_hold", 32'(level), 32'd0);
        repeat (9) cyc();
      end
    end
    chk("win_level", 32'(level), 32'd1);
    chk("win_resp_state", 32'(state), 32'd4);
    chk("win_respawn", 32'(respawn), 32'd1);
    cyc();
    chk("win_play", 32'(state), 32'd1);
    chk("win_resp_off", 32'(respawn), 32'd0);

    do_hit(3'd2, 1'b0);
    do_hit(3'd1, 1'b0);
    do_hit(3'd0, 1'b1);

    // outcomes ignored in GAME_OVER
    outcome = 2'b11;
    repeat (10) cyc();
    outcome = 2'b01;
    repeat (10) cyc();
    outcome = 2'b00;
    chk("over_ignore_state", 32'(state), 32'd5);
    chk("over_ignore_lives", 32'(lives), 32'd0);
    chk("over_ignore_level", 32'(level), 32'd1);
    do_start();

    // tick in the detection cycle is not counted
    outcome = 2'b11;
    tick    = 1'b1;
    cyc();
    outcome = 2'b00;
    chk("coin_state", 32'(state), 32'd2);
    chk("coin_flash", 32'(flash), 32'hFF);
    repeat (3) cyc();
    chk("coin_hold", 32'(state), 32'd2);
    chk("coin_flash3", 32'(flash), 32'h00);
    cyc();
    tick = 1'b0;
    chk("coin_resp", 32'(state), 32'd4);
    cyc();
    chk("coin_play", 32'(state), 32'd1);

    // reserved code 10 and start in PLAY ignored
    outcome = 2'b10;
    start_n = 1'b0;
    repeat (5) cyc();
    outcome = 2'b00;
    start_n = 1'b1;
    chk("rsv_state", 32'(state), 32'd1);
    chk("rsv_lives", 32'(lives), 32'd3);
    chk("rsv_level", 32'(level), 32'd1);

    // async reset two ticks into HIT_FLASH
    outcome = 2'b01;
    cyc();
    outcome = 2'b00;
    tick = 1'b1;
    repeat (2) cyc();
    tick = 1'b0;
    chk("ar_pre_state", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_lives", 32'(lives), 32'd3);
    chk("ar_flash", 32'(flash), 32'h00);
    chk("ar_pause", 32'(pause), 32'd1);
    chk("ar_respawn", 32'(respawn), 32'd0);
    cyc();
    chk("ar_resp_hold", 32'(respawn), 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("ar_idle", 32'(state), 32'd0);
    chk("ar_idle_resp", 32'(respawn), 32'd0);

    // level saturates at 15
    do_start();
    for (int k = 1; k <= 16; k++) begin
      fast_win();
      chk("sat_level", 32'(level), (k > 15) ? 32'd15 : 32'(k));
    end
    chk("sat_play", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
